// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, delayed sync/blank
// pipeline aligned with the external pixel pipeline, and 3-3-2 to 8-8-8 colour expansion.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_LAST    = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [10:0] hCount_q, hCount_d;
    logic [10:0] vCount_q, vCount_d;

    logic hSyncRaw, vSyncRaw, blankNRaw;

    logic [PIPE_DELAY-1:0] hsPipe_q;
    logic [PIPE_DELAY-1:0] vsPipe_q;
    logic [PIPE_DELAY-1:0] blPipe_q;

    logic       hSync_q, vSync_q, blankN_q;
    logic [7:0] red_q, green_q, blue_q;

    // The line counter only advances on the clock where the pixel counter wraps.
    always_comb begin
        hCount_d = hCount_q + 11'd1;
        vCount_d = vCount_q;
        if (hCount_q == H_LAST) begin
            hCount_d = '0;
            vCount_d = (vCount_q == V_LAST) ? 11'd0 : vCount_q + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hCount_q <= '0;
            vCount_q <= '0;
        end else begin
            hCount_q <= hCount_d;
            vCount_q <= vCount_d;
        end
    end

    always_comb begin
        hSyncRaw  = !((hCount_q >= HS_FIRST) && (hCount_q <= HS_LAST));
        vSyncRaw  = !((vCount_q >= VS_FIRST) && (vCount_q <= VS_LAST));
        blankNRaw = (hCount_q < H_VIS) && (vCount_q < V_VIS);
    end

    // Sync/blank travel alongside the external pixel pipeline so they meet RGBIn in step.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hsPipe_q <= '1;
            vsPipe_q <= '1;
            blPipe_q <= '0;
        end else begin
            hsPipe_q[0] <= hSyncRaw;
            vsPipe_q[0] <= vSyncRaw;
            blPipe_q[0] <= blankNRaw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hsPipe_q[i] <= hsPipe_q[i-1];
                vsPipe_q[i] <= vsPipe_q[i-1];
                blPipe_q[i] <= blPipe_q[i-1];
            end
        end
    end

    // Colour is only looked at while blank is inactive, so an undriven RGBIn in blanking stays out.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hSync_q  <= 1'b1;
            vSync_q  <= 1'b1;
            blankN_q <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            hSync_q  <= hsPipe_q[PIPE_DELAY-1];
            vSync_q  <= vsPipe_q[PIPE_DELAY-1];
            blankN_q <= blPipe_q[PIPE_DELAY-1];
            if (blPipe_q[PIPE_DELAY-1]) begin
                red_q   <= {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]};
                green_q <= {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]};
                blue_q  <= {RGBIn[1:0], RGBIn[1:0], RGBIn[1:0], RGBIn[1:0]};
            end else begin
                red_q   <= '0;
                green_q <= '0;
                blue_q  <= '0;
            end
        end
    end

    assign pixelX = hCount_q;
    assign pixelY = vCount_q;

    // Gated by reset so the held-at-origin counters do not announce a frame during reset.
    assign startOfFrame = resetN && (hCount_q == '0) && (vCount_q == '0);

    assign hSync  = hSync_q;
    assign vSync  = vSync_q;
    assign blankN = blankN_q;
    assign red    = red_q;
    assign green  = green_q;
    assign blue   = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster, compared cycle by cycle
// against a reference model derived from raster position arithmetic.
module tb_vga_timing_gen;

    localparam int HV = 40, HF = 4, HS = 8, HB = 6;
    localparam int VV = 30, VF = 2, VS = 2, VB = 3;
    localparam int P  = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk;
    logic        resetN;
    logic [7:0]  RGBIn;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame;
    logic [7:0]  red, green, blue;
    logic        hSync, vSync, blankN;

    int checkCount = 0;
    int passCount  = 0;
    int nCyc       = 0;
    logic [7:0] rgbHist [0:8191];

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .PIPE_DELAY(P)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .RGBIn(RGBIn),
        .pixelX(pixelX),
        .pixelY(pixelY),
        .startOfFrame(startOfFrame),
        .red(red),
        .green(green),
        .blue(blue),
        .hSync(hSync),
        .vSync(vSync),
        .blankN(blankN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, nCyc, obs, exp);
    endtask

    function automatic bit isVisible(input int t);
        return ((t % HT) < HV) && (((t / HT) % VT) < VV);
    endfunction

    // RGBIn driven in cycle n belongs to the pixel shown on pixelX/pixelY in cycle n-P.
    task automatic applyStimulus(input int n);
        logic [7:0] v;
        int m, ph, pv;
        v  = 8'($urandom);
        m  = n - P;
        if (m >= 0) begin
            ph = m % HT;
            pv = (m / HT) % VT;
            if (!isVisible(m) && ($urandom_range(0, 3) == 0)) v = 'x;
            if (ph == 10 && pv == 10)      v = 8'hE0;
            if (ph == HV + 5 && pv == 10)  v = 8'h1F;
            if (ph == 10 && pv == VV + 2)  v = 8'hFF;
        end
        RGBIn = v;
        rgbHist[n] = v;
    endtask

    task automatic checkReset();
        check("rst_pixelX", pixelX, 11'd0);
        check("rst_pixelY", pixelY, 11'd0);
        check("rst_sof", {10'd0, startOfFrame}, 11'd0);
        check("rst_hSync", {10'd0, hSync}, 11'd1);
        check("rst_vSync", {10'd0, vSync}, 11'd1);
        check("rst_blankN", {10'd0, blankN}, 11'd0);
        check("rst_red", {3'd0, red}, 11'd0);
        check("rst_green", {3'd0, green}, 11'd0);
        check("rst_blue", {3'd0, blue}, 11'd0);
    endtask

    task automatic checkOutput(input int n);
        int t, h, v, r3, g3, b2;
        logic expHs, expVs, expBl;
        logic [7:0] expR, expG, expB, c;
        check("pixelX", pixelX, 11'(n % HT));
        check("pixelY", pixelY, 11'((n / HT) % VT));
        check("sof", {10'd0, startOfFrame}, {10'd0, (n % FT) == 0});
        expHs = 1'b1; expVs = 1'b1; expBl = 1'b0;
        expR = '0; expG = '0; expB = '0;
        if (n >= P + 1) begin
            t = n - P - 1;
            h = t % HT;
            v = (t / HT) % VT;
            expHs = !(h >= HV + HF && h < HV + HF + HS);
            expVs = !(v >= VV + VF && v < VV + VF + VS);
            expBl = isVisible(t);
            if (expBl) begin
                c  = rgbHist[n-1];
                r3 = int'(c[7:5]);
                g3 = int'(c[4:2]);
                b2 = int'(c[1:0]);
                expR = 8'(r3 * 36 + r3 / 2);
                expG = 8'(g3 * 36 + g3 / 2);
                expB = 8'(b2 * 85);
            end
        end
        check("hSync", {10'd0, hSync}, {10'd0, expHs});
        check("vSync", {10'd0, vSync}, {10'd0, expVs});
        check("blankN", {10'd0, blankN}, {10'd0, expBl});
        check("red", {3'd0, red}, {3'd0, expR});
        check("green", {3'd0, green}, {3'd0, expG});
        check("blue", {3'd0, blue}, {3'd0, expB});
    endtask

    task automatic runCycle();
        @(negedge clk);
        checkOutput(nCyc);
        @(posedge clk);
        #1;
        nCyc++;
        applyStimulus(nCyc);
    endtask

    initial begin
        resetN = 1'b0;
        RGBIn  = 8'h00;
        repeat (2) @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            checkReset();
        end

        $display("[TB] releasing reset, running two frames");
        @(posedge clk);
        #1;
        resetN = 1'b1;
        nCyc = 0;
        applyStimulus(0);
        repeat (2 * FT + 100) runCycle();

        // Walk to raster position (20,15), then pull reset mid-frame.
        for (int k = 0; k < FT; k++) begin
            if ((nCyc % HT) == 20 && ((nCyc / HT) % VT) == 15) break;
            runCycle();
        end
        check("reached_20_15", 11'(nCyc % HT), 11'd20);
        $display("[TB] asserting reset mid-frame");
        resetN = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkReset();
            @(posedge clk);
        end
        #1;
        resetN = 1'b1;
        nCyc = 0;
        applyStimulus(0);
        repeat (FT + 200) runCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter PIPE_DELAY, default 2, clocks from pixelX/pixelY to valid RGBIn; legal range 1..4.
REQ-006 SHALL have port clk, input, 1, pixel clock (25 MHz nominal); only clock.
REQ-007 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port RGBIn, input, 8, pixel colour from screen mux, 3-3-2 format (R[7:5], G[4:2], B[1:0]).
REQ-009 SHALL have ports pixelX and pixelY, output, 11 each, registered current horizontal/vertical counter.
REQ-010 SHALL have port startOfFrame, output, 1, one-clock frame pulse.
REQ-011 SHALL have ports red, green, blue, output, 8 each, expanded DAC colour.
REQ-012 SHALL have ports hSync, vSync, output, 1 each, active-low syncs; port blankN, output, 1, high in active video.

Function
REQ-013 SHALL keep hCount 0..H_TOTAL-1, H_TOTAL = sum of H params (800); increment every clock; wrap to 0.
REQ-014 SHALL keep vCount 0..V_TOTAL-1, V_TOTAL = sum of V params (525); increment only in the clock where hCount wraps.
REQ-015 SHALL wrap vCount to 0 when hCount wraps and vCount = V_TOTAL-1; both counters wrap in the same clock.
REQ-016 SHALL drive pixelX/pixelY to the registered hCount/vCount, including porch/sync values up to 799/524.
REQ-017 SHALL assert startOfFrame for exactly one clock, the clock in which pixelX=0 and pixelY=0.
REQ-018 SHALL compute raw sync: hSync low for hCount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751).
REQ-019 SHALL compute raw sync: vSync low for vCount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491), for whole lines.
REQ-020 SHALL compute raw blankN high only when hCount < H_VISIBLE and vCount < V_VISIBLE.
REQ-021 SHALL delay raw hSync/vSync/blankN through a PIPE_DELAY-stage shift register, then one output register.
REQ-022 SHALL register RGBIn in the cycle t+PIPE_DELAY for the pixel presented on pixelX/pixelY in cycle t.
REQ-023 SHALL present red/green/blue, hSync, vSync and blankN for that pixel together in cycle t+PIPE_DELAY+1.
REQ-024 SHALL expand colour by bit replication: red={R,R,R[2:1]}, green={G,G,G[2:1]}, blue={B,B,B,B}.
REQ-025 SHALL force red/green/blue to 0 whenever the delayed blankN is 0, regardless of RGBIn.
REQ-026 SHALL treat RGBIn as don't-care outside active video; X on RGBIn during blanking SHALL NOT propagate.

Reset
REQ-027 SHALL, while resetN=0, hold hCount=vCount=0, pixelX=pixelY=0, startOfFrame=0.
REQ-028 SHALL, while resetN=0, hold hSync=vSync=1, blankN=0, red=green=blue=0, and all pipeline stages at hSync=1, vSync=1, blankN=0.
REQ-029 SHALL, on reset mid-frame, discard the frame; first clock after release shows pixelX=0, pixelY=0, startOfFrame=1.
REQ-030 SHALL emit no active video until PIPE_DELAY+1 clocks after release.

Verification
REQ-031 Release reset, run 420000 clocks -> startOfFrame pulses every 420000 clocks; pixelX max 799, pixelY max 524.
REQ-032 Line (0..799) -> after PIPE_DELAY+1 = 3 clocks, hSync low exactly 96 clocks starting at delayed count 656; blankN high 640 clocks.
REQ-033 Frame -> vSync low for lines 490..491 (1600 clocks); blankN 0 for all of lines 480..524.
REQ-034 RGBIn=8'hE0 at pixel (10,10) -> red=8'hFF, green=0, blue=0 at output 3 clocks later.
REQ-035 RGBIn=8'h1F, 8'hFF at pixel (700,10) and (10,500) -> red/green/blue=0 at both output positions.
REQ-036 Assert resetN=0 at pixel (300,200) for 5 clocks -> outputs match REQ-028; pixelX=0, pixelY=0, startOfFrame=1 the first clock after release.
